speaker_sched: RTL

Sequencer for the speaker toggle path. Merges CPU soft-switch accesses at the speaker address with a hardware note engine that plays queued tones. The engine emits toggles at a programmed half-period for a programmed number of half-periods. Output is a single-cycle toggle strobe that feeds the existing audio/speaker block, which flips its level on each strobe.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/note_fifo.sv | 91 +++++++++
 rtl/speaker_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types for the speaker toggle path.
//   SPKR_ADDR_DEF - default CPU address whose access toggles the speaker
//   note_t        - one queued note: rest flag, half-period, half-period count
//   sched_state_t - note engine states
package audio_pkg;

  localparam logic [15:0] SPKR_ADDR_DEF = 16'hC030;

  typedef struct packed {
    logic        rest;
    logic [15:0] half;
    logic [15:0] cnt;
  } note_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } sched_state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of notes feeding the note engine.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, din       - enqueue din when high
//   pop             - dequeue head (ignored when empty)
//   flush           - empty the queue; a simultaneous push is dropped silently
//   clr_ovf         - clear the sticky overflow flag
//   dout            - current head entry
//   full, empty     - registered occupancy flags
//   ovf             - sticky: a push was dropped because the queue was full
//   nonempty_next   - queue will hold at least one entry after this cycle
module note_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  note_t din,
  input  logic  pop,
  input  logic  flush,
  input  logic  clr_ovf,
  output note_t dout,
  output logic  full,
  output logic  empty,
  output logic  ovf,
  output logic  nonempty_next
);

  localparam int unsigned AW = $clog2(DEPTH);

  note_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign dout  = mem[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push while full still fits.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  assign nonempty_next = (count_d != '0);

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push && !flush && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/speaker_sched.sv
// Speaker toggle sequencer: merges CPU soft-switch accesses with a queued
// tone engine into one registered single-cycle toggle strobe.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   addr                            - CPU bus address
//   note_wr, note_rest,
//   note_half, note_cnt             - push one note into the queue
//   flush                           - clear queue, abort note, clear ovf
//   toggle                          - one-cycle strobe to the audio block
//   busy                            - engine in LOAD or RUN
//   empty, full, ovf                - queue status
// Build option: define AUDIO_CPU_PREEMPT_EN to let a CPU access while busy
// abort the engine and clear the queue (ovf is kept).
module speaker_sched
  import audio_pkg::*;
#(
  parameter logic [15:0] SPKR_ADDR = SPKR_ADDR_DEF,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        note_wr,
  input  logic        note_rest,
  input  logic [15:0] note_half,
  input  logic [15:0] note_cnt,
  input  logic        flush,
  output logic        toggle,
  output logic        busy,
  output logic        empty,
  output logic        full,
  output logic        ovf
);

  sched_state_t state_q, state_d;
  logic [15:0]  timer_q, timer_d, remain_q, remain_d, half_q, half_d;
  logic         rest_q, rest_d;
  logic         match_q, cpu_hit, preempt, kill;
  logic         toggle_q, toggle_d, eng_fire, pop, avail;
  logic [15:0]  head_half;
  note_t        head, din;

  assign din = '{rest: note_rest, half: note_half, cnt: note_cnt};

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (note_wr),
    .din          (din),
    .pop          (pop),
    .flush        (kill),
    .clr_ovf      (flush),
    .dout         (head),
    .full         (full),
    .empty        (empty),
    .ovf          (ovf),
    .nonempty_next(avail)
  );

  assign cpu_hit = (addr == SPKR_ADDR) && !match_q;
  assign busy    = (state_q != IDLE);

`ifdef AUDIO_CPU_PREEMPT_EN
  assign preempt = cpu_hit && busy;
`else
  assign preempt = 1'b0;
`endif

  assign kill      = flush || preempt;
  assign head_half = (head.half < 16'd2) ? 16'd2 : head.half;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    remain_d = remain_q;
    half_d   = half_q;
    rest_d   = rest_q;
    pop      = 1'b0;
    eng_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail) state_d = LOAD;
      end
      LOAD: begin
        pop      = 1'b1;
        half_d   = head_half;
        timer_d  = head_half - 16'd1;
        remain_d = head.cnt;
        rest_d   = head.rest;
        if (head.cnt == 16'd0) begin
          state_d = avail ? LOAD : IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (timer_q == 16'd0) begin
          timer_d  = half_q - 16'd1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = avail ? LOAD : IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
          // Strobe is registered, so it is launched one cycle before timer hits 0.
          if (timer_q == 16'd1 && !rest_q) eng_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Under preemption kill masks the engine, so the CPU strobe always survives.
  assign toggle_d = cpu_hit ^ (eng_fire && !kill);
  assign toggle   = toggle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      remain_q <= '0;
      half_q   <= 16'd2;
      rest_q   <= 1'b0;
      match_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
      half_q   <= half_d;
      rest_q   <= rest_d;
      match_q  <= (addr == SPKR_ADDR);
      toggle_q <= toggle_d;
    end
  end

endmodule
